// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the instruction fetch stage
package fetch_pkg;

    // Default widths; the fetch_entry_t layout is fixed by these values.
    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 16;

    // One buffered fetch: the address it came from and the returned word.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  addr;
        logic [FETCH_INSTR_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  fetch_entry_t      push_entry_i,
    input  logic              pop_i,
    output fetch_entry_t      head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointers and occupancy; flush wins over push/pop, pointers wrap mod DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);

    // The credit scheme upstream must never overfill or underflow the buffer.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && !flush_i && full_o));
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && !flush_i && empty_o));

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: issue/credit, in-flight tracking, redirect flush
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               async_rst_n,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               redirect_en,
    output logic               pc_clk_en,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rd_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_addr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  credit_used;
    logic              fifo_empty;
    logic              fifo_full;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Issue only from registered occupancy: a pop this cycle frees its slot next cycle.
    always_comb begin
        credit_used = count + {{(CNT_W-1){1'b0}}, inflight_q};
        issue       = async_rst_n && !redirect_en && (credit_used < DEPTH_C);
        mem_rd_en   = issue;
        mem_addr    = pc;
        pc_clk_en   = issue || (async_rst_n && redirect_en);
    end

    // Response capture and decoder handshake; a redirect drops the returning word.
    always_comb begin
        push            = inflight_q && !redirect_en;
        push_entry.addr = inflight_addr_q;
        push_entry.data = mem_rd_data;
        instr_valid     = !fifo_empty && !redirect_en;
        pop             = instr_valid && instr_ready;
        instr_data      = head.data;
        instr_addr      = head.addr;
    end

    // In-flight tracking: set by an issue, otherwise cleared once the response lands.
    always_comb begin
        inflight_d      = issue;
        inflight_addr_d = issue ? pc : inflight_addr_q;
    end

    // In-flight registers.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (async_rst_n),
        .flush_i      (redirect_en),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    // A full buffer must never coexist with an outstanding fetch.
    a_full_no_inflight : assert property (@(posedge clk) disable iff (!async_rst_n)
        !(fifo_full && inflight_q));

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        async_rst_n = 1'b1;
    logic [7:0]  pc;
    logic        redirect_en = 1'b0;
    logic [7:0]  redirect_target = 8'h00;
    logic        pc_clk_en;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rd_data = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_data;
    logic [7:0]  instr_addr;

    instruction_fetch dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .pc          (pc),
        .redirect_en (redirect_en),
        .pc_clk_en   (pc_clk_en),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) pc <= 8'h00;
        else if (pc_clk_en) pc <= redirect_en ? redirect_target : pc + 8'h01;
    end

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] next_push = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         n_deliv = 0;
    int         d0;
    int         n;

    function automatic void sb_fill();
        while (exp_q.size() < 32) begin
            exp_q.push_back('{next_push, mem[next_push]});
            next_push = next_push + 8'h01;
        end
    endfunction

    function automatic void sb_restart(input logic [7:0] t);
        exp_q.delete();
        next_push = t;
        sb_fill();
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!async_rst_n) begin
            chk("valid_in_reset", int'(instr_valid), 0);
        end else begin
            if (redirect_en) chk("valid_in_redirect", int'(instr_valid), 0);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_delivery: got addr %0h expected none", instr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliv_addr", int'(instr_addr), int'(e.addr));
                    chk("deliv_data", int'(instr_data), int'(e.data));
                    n_deliv++;
                    sb_fill();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        #1 async_rst_n = 1'b0;
        instr_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_rd_en", int'(mem_rd_en), 0);
        chk("rst_pc_clk_en", int'(pc_clk_en), 0);
        chk("rst_valid", int'(instr_valid), 0);

        // Streaming from 0x00 after release
        @(posedge clk);
        #1;
        sb_restart(8'h00);
        async_rst_n = 1'b1;
        #2;
        chk("c0_rd_en", int'(mem_rd_en), 1);
        chk("c0_addr", int'(mem_addr), 8'h00);
        chk("c0_valid", int'(instr_valid), 0);
        tick(); #2;
        chk("c1_addr", int'(mem_addr), 8'h01);
        chk("c1_valid", int'(instr_valid), 0);
        tick(); #2;
        chk("c2_addr", int'(mem_addr), 8'h02);
        chk("c2_valid", int'(instr_valid), 1);
        chk("c2_instr_addr", int'(instr_addr), 8'h00);

        // Back-pressure: exactly DEPTH fetches, then drain and resume
        tick();
        redirect_en = 1'b1; redirect_target = 8'h10; instr_ready = 1'b0;
        sb_restart(8'h10);
        #2;
        chk("redir_pc_clk_en", int'(pc_clk_en), 1);
        chk("redir_rd_en", int'(mem_rd_en), 0);
        tick();
        redirect_en = 1'b0;
        n = 0;
        repeat (8) begin
            #2;
            if (mem_rd_en) n++;
            tick();
        end
        chk("full_issue_count", n, 4);
        #2;
        chk("full_rd_en", int'(mem_rd_en), 0);
        chk("full_pc_clk_en", int'(pc_clk_en), 0);
        tick();
        instr_ready = 1'b1;
        #2;
        chk("pop_cycle_rd_en", int'(mem_rd_en), 0);
        chk("pop_cycle_addr", int'(instr_addr), 8'h10);
        tick(); #2;
        chk("resume_rd_en", int'(mem_rd_en), 1);
        chk("resume_addr", int'(mem_addr), 8'h14);

        // Redirect to 0x40 with 3 buffered and 1 in flight
        tick();
        redirect_en = 1'b1; redirect_target = 8'h20; instr_ready = 1'b0;
        sb_restart(8'h20);
        tick();
        redirect_en = 1'b0;
        repeat (3) tick();
        #2;
        chk("r4_rd_en", int'(mem_rd_en), 1);
        chk("r4_addr", int'(mem_addr), 8'h23);
        tick();
        redirect_en = 1'b1; redirect_target = 8'h40; instr_ready = 1'b1;
        sb_restart(8'h40);
        #2;
        chk("r40_valid", int'(instr_valid), 0);
        chk("r40_pc_clk_en", int'(pc_clk_en), 1);
        chk("r40_rd_en", int'(mem_rd_en), 0);
        tick();
        redirect_en = 1'b0;
        #2;
        chk("r40p1_rd_en", int'(mem_rd_en), 1);
        chk("r40p1_addr", int'(mem_addr), 8'h40);
        chk("r40p1_valid", int'(instr_valid), 0);
        tick(); #2;
        chk("r40p2_valid", int'(instr_valid), 0);
        tick(); #2;
        chk("r40p3_valid", int'(instr_valid), 1);
        chk("r40p3_addr", int'(instr_addr), 8'h40);

        // Address wrap 0xFE -> 0x00
        tick();
        redirect_en = 1'b1; redirect_target = 8'hFE;
        sb_restart(8'hFE);
        tick();
        redirect_en = 1'b0;
        d0 = n_deliv;
        repeat (8) tick();
        chk("wrap_count", n_deliv - d0, 6);

        // Asynchronous reset mid-cycle with buffered and in-flight fetches
        redirect_en = 1'b1; redirect_target = 8'h80; instr_ready = 1'b0;
        sb_restart(8'h80);
        tick();
        redirect_en = 1'b0;
        repeat (3) tick();
        #3 async_rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(instr_valid), 0);
        chk("arst_rd_en", int'(mem_rd_en), 0);
        chk("arst_pc_clk_en", int'(pc_clk_en), 0);
        @(posedge clk);
        #1;
        sb_restart(8'h00);
        async_rst_n = 1'b1;
        instr_ready = 1'b1;
        #2;
        chk("arst_c0_addr", int'(mem_addr), 8'h00);
        tick(); tick(); #2;
        chk("arst_c2_valid", int'(instr_valid), 1);
        chk("arst_c2_addr", int'(instr_addr), 8'h00);

        // Random ready and redirects
        d0 = n_deliv;
        repeat (2000) begin
            tick();
            redirect_en = ($urandom_range(0, 11) == 0);
            if (redirect_en) begin
                redirect_target = 8'($urandom);
                sb_restart(redirect_target);
            end
            instr_ready = ($urandom_range(0, 3) != 0);
        end
        chk("rand_progress", int'((n_deliv - d0) > 100), 1);
        tick();
        redirect_en = 1'b0;
        instr_ready = 1'b1;
        d0 = n_deliv;
        repeat (20) tick();
        chk("drain_progress", int'((n_deliv - d0) >= 18), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
